// File: rtl/button_event_arbiter_pkg.sv
// Shared types and defaults for the button event arbiter: arbiter state encoding,
// default sizing and the debounce counter width helper.
package button_event_arbiter_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } arb_state_t;

   localparam int N_BTN_DEF        = 4;
   localparam int DEBOUNCE_CYC_DEF = 16;

   function automatic int cnt_width(input int cyc);
      return (cyc < 2) ? 1 : $clog2(cyc);
   endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Single-event valid/ready port shared by all button channels.
interface button_event_arbiter_if #(
   parameter int ID_W = 2
);
   logic            evt_valid;
   logic [ID_W-1:0] evt_id;
   logic            evt_ready;

   modport master (output evt_valid, output evt_id, input evt_ready);
   modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/button_event_arbiter_debounce.sv
// One button channel: 2-FF synchroniser, debounce counter and a registered
// one-cycle pulse on each accepted 0->1 level change.
module button_event_arbiter_debounce
   import button_event_arbiter_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYC);

   logic             sync_p0;
   logic             sync_p1;
   logic             stable;
   logic             stable_p2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0   <= 1'b0;
         sync_p1   <= 1'b0;
         stable    <= 1'b0;
         stable_p2 <= 1'b0;
         cnt       <= '0;
         rise      <= 1'b0;
      end else begin
         // p0/p1: metastability guard on the asynchronous pin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         // debounce: any agreement with the accepted level restarts the count
         if (sync_p1 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
            stable <= sync_p1;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         // p2: edge detect against the previous accepted level
         stable_p2 <= stable;
         rise      <= stable & ~stable_p2;
      end
   end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced button front end: per-channel press pulses are held as pending events
// and handed out one at a time over a valid/ready port in round-robin order.
module button_event_arbiter
   import button_event_arbiter_pkg::*;
#(
   parameter int N_BTN        = N_BTN_DEF,
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   parameter int ID_W         = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_BTN-1:0]      btn_in,
   button_event_arbiter_if.master evt,
   output logic [N_BTN-1:0]      pending,
   output logic [N_BTN-1:0]      overrun,
   input  logic                  ovr_clr
);

   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] clr;
   logic [N_BTN-1:0] set_ovr;
   arb_state_t       state;
   logic             valid;
   logic [ID_W-1:0]  cur_id;
   logic [ID_W-1:0]  last_grant;
   logic [ID_W-1:0]  pick;
   logic [ID_W-1:0]  idx;
   logic             found;
   logic             hs;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      button_event_arbiter_debounce #(
         .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .raw  (btn_in[i]),
         .rise (rise[i])
      );
   end

   assign hs            = valid & evt.evt_ready;
   assign evt.evt_valid = valid;
   assign evt.evt_id    = cur_id;

   always_comb begin
      clr = '0;
      if (hs) clr[cur_id] = 1'b1;
   end

   // A press landing on the same cycle as its own acceptance is a fresh event, not an overrun.
   assign set_ovr = rise & pending & ~clr;

   // Search starts just after the last grant so that channel gets lowest priority.
   always_comb begin
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= N_BTN; k++) begin
         idx = ID_W'((int'(last_grant) + k) % N_BTN);
         if (!found && pending[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         valid      <= 1'b0;
         cur_id     <= '0;
         last_grant <= ID_W'(N_BTN - 1);
         pending    <= '0;
         overrun    <= '0;
      end else begin
         pending <= (pending & ~clr) | rise;
         overrun <= (ovr_clr ? '0 : overrun) | set_ovr;
         case (state)
            ST_IDLE: begin
               if (|pending) begin
                  cur_id <= pick;
                  valid  <= 1'b1;
                  state  <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (evt.evt_ready) begin
                  valid      <= 1'b0;
                  last_grant <= cur_id;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               valid <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
